toy_mem: RTL and testbench
==========================

// Module: toy_mem
// PURPOSE
//  Byte-wide synchronous RAM serving toy_sch: consumes its ADDR/D_OUT/MEM_EN/RORW, returns read data on its D_IN.
//  Adds a post-reset clear sequencer and a streaming program loader so benches and board bring-up can preload code.
//  CPU accesses are ignored while clearing or loading; BUSY tells the environment when to hold the CPU in reset.
// PARAMETERS
//  DW        8     data width
//  AW        8     address width
//  DEPTH     256   words implemented (<= 2**AW)
//  INIT_VAL  8'h00 value written to every word by the clear sequence
// PORTS
//  CLK       in   1   clock, all state on rising edge
//  RESET     in   1   asynchronous, active-low reset
//  ADDR      in   AW  CPU address (toy_sch ADDR)
//  WDATA     in   DW  CPU write data (toy_sch D_OUT)
//  MEM_EN    in   1   CPU access request, one cycle per access
//  RORW      in   1   1 = read, 0 = write
//  RDATA     out  DW  read data to toy_sch D_IN
//  LD_START  in   1   pulse: begin program load at address 0
//  LD_LEN    in   AW  words to load, sampled with LD_START; 0 means DEPTH
//  LD_VALID  in   1   loader byte valid
//  LD_DATA   in   DW  loader byte
//  LD_READY  out  1   loader byte accepted when LD_VALID & LD_READY
//  LD_DONE   out  1   one-cycle pulse after last load byte written
//  BUSY      out  1   1 in CLEAR or LOAD
//  ERR       out  1   sticky out-of-range flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (RESET=0): state=CLEAR, clr/ld counter=0, RDATA=0, LD_READY=0, LD_DONE=0, BUSY=1, ERR=0. Array not reset.
//  FSM CLEAR: write INIT_VAL to mem[cnt] each cycle, cnt++; after cnt==DEPTH-1 written -> SERVE. Takes DEPTH cycles.
//  FSM SERVE: BUSY=0, LD_READY=0.
//   - MEM_EN&RORW at edge k: RDATA=mem[ADDR] for exactly cycle k..k+1, returns to 0 at next edge (1-cycle pulse).
//   - MEM_EN&~RORW at edge k: mem[ADDR]<=WDATA; RDATA=0. A read of same address at edge k+1 returns new data.
//   - no MEM_EN: RDATA=0.
//   - LD_START: latch LD_LEN, cnt=0, -> LOAD next cycle. If MEM_EN asserted same cycle, CPU access completes first.
//  FSM LOAD: LD_READY=1, BUSY=1; on LD_VALID&LD_READY mem[cnt]<=LD_DATA, cnt++. LD_VALID gaps allowed, no timeout.
//   After byte number len (len=DEPTH when LD_LEN=0, else min(LD_LEN,DEPTH)) is written: LD_DONE=1 one cycle, -> SERVE.
//   MEM_EN ignored (no write, RDATA=0); LD_START ignored.
//  LD_START during CLEAR ignored. RESET mid-CLEAR or mid-LOAD: abort immediately, restart CLEAR on release.
//  Address index = ADDR modulo DEPTH (low bits) when DEPTH is a power of two; otherwise see ERR rule.
// CONFIGURATION
//  TOY_MEM_RANGE_CHECK_EN defined: CPU access with ADDR>=DEPTH sets ERR=1 (sticky until RESET); such a read returns
//   RDATA=0 pulse, such a write is dropped. Not defined: ERR tied 0, ADDR wraps modulo DEPTH, out-of-range writes land.
// STRUCTURE
//  toy_pkg: state enum {CLEAR,SERVE,LOAD} as localparams, RD=1'b1/WR=1'b0 RORW encodings, default DW/AW.
//  One sub-module: toy_mem_array (single-port sync-write RAM, async-read array, DEPTH x DW); FSM, counter, mux in top.
// TESTING
//  1 Reset release -> BUSY=1 for exactly 256 cycles; then read 0x05 -> RDATA=0x00 pulse one cycle after request.
//  2 LD_START LD_LEN=4, bytes 0x01,0x00,0xAA,0x00 with 2-cycle gaps -> LD_DONE once; reads 0x00..0x03 return them.
//  3 Write 0xFE to 0x10, read 0x10 next cycle -> RDATA=0xFE for one cycle, 0x00 cycle after.
//  4 LD_START + MEM_EN read of 0x02 same cycle -> read returns 0xAA, then BUSY=1, LD_READY=1 next cycle.
//  5 RESET low after 2 of 4 load bytes -> after release, full CLEAR; reads 0x00/0x01 return INIT_VAL, no LD_DONE.
//  6 TOY_MEM_RANGE_CHECK_EN, DEPTH=128: write 0xCC to 0x80 -> ERR=1 sticky, read 0x00 still INIT_VAL; read 0x80 -> 0x00.

Source files
------------

// File: rtl/toy_mem_pkg.sv
// Shared types and defaults for the toy_mem RAM, its clear sequencer and program loader.
package toy_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    SERVE = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  localparam int DEFAULT_DW    = 8;
  localparam int DEFAULT_AW    = 8;
  localparam int DEFAULT_DEPTH = 256;

  // Index width into the array; a one-word memory still needs a 1-bit index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/toy_mem_if.sv
// CPU access bus, program-loader stream and status flags between the environment and toy_mem.
interface toy_mem_if
  import toy_mem_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) ();

  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          mem_en;
  logic          rorw;
  logic [DW-1:0] rdata;

  logic          ld_start;
  logic [AW-1:0] ld_len;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_done;

  logic          busy;
  logic          err;

  modport master (
    output addr, wdata, mem_en, rorw, ld_start, ld_len, ld_valid, ld_data,
    input  rdata, ld_ready, ld_done, busy, err
  );

  modport slave (
    input  addr, wdata, mem_en, rorw, ld_start, ld_len, ld_valid, ld_data,
    output rdata, ld_ready, ld_done, busy, err
  );

endinterface

// File: rtl/toy_mem_array.sv
// Single-port storage: synchronous write, asynchronous read, DEPTH x DW words, contents not reset.
module toy_mem_array #(
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Indices past DEPTH only occur for non-power-of-two depths; they are dropped / read as zero.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/toy_mem.sv
// Byte RAM for toy_sch with post-reset clear and streaming program loader.
// Optional feature: define TOY_MEM_RANGE_CHECK_EN to flag and drop CPU accesses with addr >= DEPTH.
module toy_mem
  import toy_mem_pkg::*;
#(
  parameter int            DW       = DEFAULT_DW,
  parameter int            AW       = DEFAULT_AW,
  parameter int            DEPTH    = DEFAULT_DEPTH,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input logic      clk,
  input logic      rst_n,
  toy_mem_if.slave bus
);

  localparam int          IW      = idx_width(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ld_done_q, ld_done_d;

  logic          we;
  logic [IW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] arr_rdata;
  logic [IW-1:0] cpu_idx;
  logic [IW-1:0] cnt_idx;
  logic [AW:0]   ld_len_ext;
  logic          in_range;

  assign cpu_idx    = bus.addr[IW-1:0];
  assign cnt_idx    = cnt_q[IW-1:0];
  assign ld_len_ext = {1'b0, bus.ld_len};

`ifdef TOY_MEM_RANGE_CHECK_EN
  logic err_q;

  assign in_range = ({1'b0, bus.addr} < DEPTH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state_q == SERVE) && bus.mem_en && !in_range) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign in_range = 1'b1;
  assign bus.err  = 1'b0;
`endif

  toy_mem_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (cpu_idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      len_q     <= '0;
      rdata_q   <= '0;
      ld_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      rdata_q   <= rdata_d;
      ld_done_q <= ld_done_d;
    end
  end

  // The array has one write port, shared by clear, CPU and loader according to state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    rdata_d   = '0;
    ld_done_d = 1'b0;
    we        = 1'b0;
    waddr     = cpu_idx;
    wdata     = bus.wdata;

    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt_idx;
        wdata = INIT_VAL;
        if (cnt_q == DEPTH_W - CNT_ONE) begin
          cnt_d   = '0;
          state_d = SERVE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      SERVE: begin
        if (bus.mem_en && in_range) begin
          if (bus.rorw == RD) begin
            rdata_d = arr_rdata;
          end else begin
            we = 1'b1;
          end
        end
        // A CPU access in the same cycle as ld_start still completes above.
        if (bus.ld_start) begin
          len_d   = ((ld_len_ext == '0) || (ld_len_ext > DEPTH_W)) ? DEPTH_W : ld_len_ext;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (bus.ld_valid) begin
          we    = 1'b1;
          waddr = cnt_idx;
          wdata = bus.ld_data;
          if (cnt_q == len_q - CNT_ONE) begin
            ld_done_d = 1'b1;
            cnt_d     = '0;
            state_d   = SERVE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.rdata    = rdata_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_ready = (state_q == LOAD);
  assign bus.busy     = (state_q != SERVE);

endmodule

// File: tb/tb_toy_mem.sv
// Directed self-checking bench for toy_mem: clear timing, loader, CPU read/write, reset abort.
// Build with TOY_MEM_RANGE_CHECK_EN to exercise the out-of-range flag on a 128-word memory.
module tb_toy_mem;
  import toy_mem_pkg::*;

`ifdef TOY_MEM_RANGE_CHECK_EN
  localparam int DEPTH = 128;
`else
  localparam int DEPTH = 256;
`endif
  localparam logic [7:0] INIT_VAL = 8'h00;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  toy_mem_if #(.DW(8), .AW(8)) bus ();

  toy_mem #(
    .DW       (8),
    .AW       (8),
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.mem_en   = 1'b0;
    bus.rorw     = RD;
    bus.ld_start = 1'b0;
    bus.ld_len   = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b want 1", bus.busy); else passes++;
    checks++; if (bus.rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %h want 00", bus.rdata); else passes++;
    checks++; if (bus.ld_ready !== 1'b0) $display("[TB] FAIL reset_ld_ready: got %b want 0", bus.ld_ready); else passes++;
    checks++; if (bus.ld_done !== 1'b0) $display("[TB] FAIL reset_ld_done: got %b want 0", bus.ld_done); else passes++;
    checks++; if (bus.err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", bus.err); else passes++;

    rst_n = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < DEPTH + 16) begin
      tick();
      n++;
    end
    checks++; if (n != DEPTH) $display("[TB] FAIL clear_cycles: got %0d want %0d", n, DEPTH); else passes++;

    bus.addr   = 8'h05;
    bus.rorw   = RD;
    bus.mem_en = 1'b1;
    tick();
    bus.mem_en = 1'b0;
    checks++; if (bus.rdata !== INIT_VAL) $display("[TB] FAIL read_after_clear: got %h want %h", bus.rdata, INIT_VAL); else passes++;
    tick();
    checks++; if (bus.rdata !== 8'h00) $display("[TB] FAIL read_pulse_end: got %h want 00", bus.rdata); else passes++;
  endtask

  task automatic test_load_gaps();
    logic [7:0] bytes_in [4];
    int done_cnt;
    logic last_done;
    bytes_in = '{8'h01, 8'h00, 8'hAA, 8'h00};
    done_cnt = 0;

    bus.ld_len   = 8'd4;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL load_busy: got %b want 1", bus.busy); else passes++;
    checks++; if (bus.ld_ready !== 1'b1) $display("[TB] FAIL load_ready: got %b want 1", bus.ld_ready); else passes++;

    last_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (2) begin
        tick();
        if (bus.ld_done === 1'b1) done_cnt++;
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = bytes_in[i];
      tick();
      bus.ld_valid = 1'b0;
      last_done = bus.ld_done;
      if (bus.ld_done === 1'b1) done_cnt++;
    end
    checks++; if (last_done !== 1'b1) $display("[TB] FAIL ld_done_timing: got %b want 1", last_done); else passes++;
    repeat (3) begin
      tick();
      if (bus.ld_done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 1) $display("[TB] FAIL ld_done_count: got %0d want 1", done_cnt); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL load_exit_busy: got %b want 0", bus.busy); else passes++;

    // Back-to-back reads: each cycle's data belongs to the address presented before that edge.
    bus.rorw   = RD;
    bus.mem_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.addr = 8'(i);
      tick();
      checks++;
      if (bus.rdata !== bytes_in[i]) $display("[TB] FAIL load_readback[%0d]: got %h want %h", i, bus.rdata, bytes_in[i]);
      else passes++;
    end
    bus.mem_en = 1'b0;
    tick();
    checks++; if (bus.rdata !== 8'h00) $display("[TB] FAIL readback_idle: got %h want 00", bus.rdata); else passes++;
  endtask

  task automatic test_write_read();
    bus.addr   = 8'h10;
    bus.wdata  = 8'hFE;
    bus.rorw   = WR;
    bus.mem_en = 1'b1;
    tick();
    checks++; if (bus.rdata !== 8'h00) $display("[TB] FAIL write_rdata: got %h want 00", bus.rdata); else passes++;
    bus.rorw = RD;
    tick();
    bus.mem_en = 1'b0;
    checks++; if (bus.rdata !== 8'hFE) $display("[TB] FAIL raw_read: got %h want FE", bus.rdata); else passes++;
    tick();
    checks++; if (bus.rdata !== 8'h00) $display("[TB] FAIL raw_pulse_end: got %h want 00", bus.rdata); else passes++;
  endtask

  task automatic test_start_with_read();
    bus.addr     = 8'h02;
    bus.rorw     = RD;
    bus.mem_en   = 1'b1;
    bus.ld_len   = 8'd4;
    bus.ld_start = 1'b1;
    tick();
    bus.mem_en   = 1'b0;
    bus.ld_start = 1'b0;
    checks++; if (bus.rdata !== 8'hAA) $display("[TB] FAIL start_read: got %h want AA", bus.rdata); else passes++;
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL start_busy: got %b want 1", bus.busy); else passes++;
    checks++; if (bus.ld_ready !== 1'b1) $display("[TB] FAIL start_ready: got %b want 1", bus.ld_ready); else passes++;

    bus.addr   = 8'h00;
    bus.mem_en = 1'b1;
    tick();
    bus.mem_en = 1'b0;
    checks++; if (bus.rdata !== 8'h00) $display("[TB] FAIL load_read_ignored: got %h want 00", bus.rdata); else passes++;
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] partial [2];
    int done_cnt;
    int n;
    partial  = '{8'h11, 8'h22};
    done_cnt = 0;

    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = partial[i];
      tick();
      if (bus.ld_done === 1'b1) done_cnt++;
    end
    bus.ld_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL midload_busy: got %b want 1", bus.busy); else passes++;

    rst_n = 1'b0;
    tick();
    checks++; if (bus.ld_ready !== 1'b0) $display("[TB] FAIL abort_ready: got %b want 0", bus.ld_ready); else passes++;
    rst_n = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < DEPTH + 16) begin
      tick();
      if (bus.ld_done === 1'b1) done_cnt++;
      n++;
    end
    checks++; if (n != DEPTH) $display("[TB] FAIL reclear_cycles: got %0d want %0d", n, DEPTH); else passes++;
    checks++; if (done_cnt != 0) $display("[TB] FAIL abort_ld_done: got %0d want 0", done_cnt); else passes++;

    bus.rorw = RD;
    for (int i = 0; i < 3; i++) begin
      bus.addr   = (i == 2) ? 8'h10 : 8'(i);
      bus.mem_en = 1'b1;
      tick();
      bus.mem_en = 1'b0;
      checks++;
      if (bus.rdata !== INIT_VAL) $display("[TB] FAIL reclear_read[%0d]: got %h want %h", i, bus.rdata, INIT_VAL);
      else passes++;
      tick();
    end
  endtask

`ifdef TOY_MEM_RANGE_CHECK_EN
  task automatic test_range_check();
    checks++; if (bus.err !== 1'b0) $display("[TB] FAIL err_before: got %b want 0", bus.err); else passes++;
    bus.addr   = 8'h80;
    bus.wdata  = 8'hCC;
    bus.rorw   = WR;
    bus.mem_en = 1'b1;
    tick();
    bus.mem_en = 1'b0;
    checks++; if (bus.err !== 1'b1) $display("[TB] FAIL err_set: got %b want 1", bus.err); else passes++;

    bus.addr   = 8'h00;
    bus.rorw   = RD;
    bus.mem_en = 1'b1;
    tick();
    bus.mem_en = 1'b0;
    checks++; if (bus.rdata !== INIT_VAL) $display("[TB] FAIL oor_write_dropped: got %h want %h", bus.rdata, INIT_VAL); else passes++;

    bus.addr   = 8'h80;
    bus.mem_en = 1'b1;
    tick();
    bus.mem_en = 1'b0;
    checks++; if (bus.rdata !== 8'h00) $display("[TB] FAIL oor_read: got %h want 00", bus.rdata); else passes++;
    repeat (3) tick();
    checks++; if (bus.err !== 1'b1) $display("[TB] FAIL err_sticky: got %b want 1", bus.err); else passes++;
  endtask
`else
  task automatic test_err_tied();
    bus.addr   = 8'hFF;
    bus.wdata  = 8'h5A;
    bus.rorw   = WR;
    bus.mem_en = 1'b1;
    tick();
    bus.rorw = RD;
    tick();
    bus.mem_en = 1'b0;
    checks++; if (bus.rdata !== 8'h5A) $display("[TB] FAIL top_addr_read: got %h want 5A", bus.rdata); else passes++;
    checks++; if (bus.err !== 1'b0) $display("[TB] FAIL err_tied: got %b want 0", bus.err); else passes++;
    tick();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_load_gaps();
    test_write_read();
    test_start_with_read();
    test_reset_mid_load();
`ifdef TOY_MEM_RANGE_CHECK_EN
    test_range_check();
`else
    test_err_tied();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
